// File: rtl/md_pad_responder_if.sv
// Pad-side signal bundle for the MD pad responder: host select, button inputs,
// active-low pad data lines and the phase debug port.
interface md_pad_responder_if;
    logic        pad_sel;
    logic [11:0] btn;
    logic [5:0]  pad_d;
    logic [2:0]  phase;

    modport master (output pad_sel, btn, input pad_d, phase);
    modport slave  (input pad_sel, btn, output pad_d, phase);
endinterface

// File: rtl/md_pad_responder.sv
// MD-style controller pad responder: answers host select toggles with
// 3-button or 6-button data, tracking falling-edge phase with an idle timeout.
module md_pad_responder #(
    parameter int unsigned CLK_HZ     = 48000000,
    parameter int unsigned TIMEOUT_US = 1500,
    parameter bit          SIX_BTN    = 1'b1
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    md_pad_responder_if.slave    pad
);

    localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int unsigned IDLE_W      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);
    localparam logic [2:0]  F_MAX       = SIX_BTN ? 3'd4 : 3'd2;

    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;
    localparam int unsigned BTN_A     = 4;
    localparam int unsigned BTN_B     = 5;
    localparam int unsigned BTN_C     = 6;
    localparam int unsigned BTN_X     = 7;
    localparam int unsigned BTN_Y     = 8;
    localparam int unsigned BTN_Z     = 9;
    localparam int unsigned BTN_START = 10;
    localparam int unsigned BTN_MODE  = 11;

    logic              sync1_q, sync2_q, sel_prev_q;
    logic [2:0]        f_q, f_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [5:0]        pad_data_q, pad_data_d;
    logic              sel_rise, sel_fall;
    logic [11:0]       b;

    assign b        = pad.btn;
    assign sel_rise = sync2_q & ~sel_prev_q;
    assign sel_fall = ~sync2_q & sel_prev_q;

    // Phase and idle tracking; a select edge takes priority over timeout expiry.
    always_comb begin
        f_d    = f_q;
        idle_d = idle_q;
        if (sel_rise || sel_fall) begin
            idle_d = '0;
            if (sel_fall && (f_q < F_MAX)) begin
                f_d = f_q + 3'd1;
            end
        end else if (idle_q == IDLE_MAX) begin
            f_d = '0;
        end else begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    // Response mux uses the synchronised select and the post-update phase.
    always_comb begin
        pad_data_d = ~{b[BTN_C], b[BTN_B], b[BTN_RIGHT], b[BTN_LEFT], b[BTN_DOWN], b[BTN_UP]};
        if (sync2_q) begin
            if (SIX_BTN && (f_d == 3'd3)) begin
                pad_data_d = ~{b[BTN_C], b[BTN_B], b[BTN_MODE], b[BTN_X], b[BTN_Y], b[BTN_Z]};
            end
        end else begin
            if (SIX_BTN && (f_d == 3'd3)) begin
                pad_data_d = ~{b[BTN_START], b[BTN_A], 4'b1111};
            end else if (SIX_BTN && (f_d == 3'd4)) begin
                pad_data_d = ~{b[BTN_START], b[BTN_A], 4'b0000};
            end else begin
                pad_data_d = ~{b[BTN_START], b[BTN_A], 1'b1, 1'b1, b[BTN_DOWN], b[BTN_UP]};
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            sel_prev_q <= 1'b1;
            f_q        <= '0;
            idle_q     <= '0;
            pad_data_q <= 6'h3F;
        end else begin
            sync1_q    <= pad.pad_sel;
            sync2_q    <= sync1_q;
            sel_prev_q <= sync2_q;
            f_q        <= f_d;
            idle_q     <= idle_d;
            pad_data_q <= pad_data_d;
        end
    end

    assign pad.pad_d = pad_data_q;
    assign pad.phase = f_q;

endmodule

// File: doc/md_pad_responder.md
MD_PAD_RESPONDER -- requirements
Module: md_pad_responder

Interface
REQ-001 SHALL have parameter CLK_HZ, default 48000000, meaning clk_sys frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT_US, default 1500, meaning idle time after which the 6-button phase resets.
REQ-003 SHALL have parameter SIX_BTN, default 1; 1 enables the 6-button extended phases, 0 gives 3-button-only behaviour.
REQ-004 clk_sys  input  1  sole clock; all state on its rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 pad_sel  input  1  select (TH) line from the host, asynchronous to clk_sys.
REQ-007 btn  input  12  buttons, active-high: {mode,start,z,y,x,c,b,a,right,left,down,up}.
REQ-008 pad_d  output  6  pad data lines, active-low, registered: [0]=D0 … [3]=D3, [4]=TL, [5]=TR.
REQ-009 phase  output  3  debug: current falling-edge count f, 0..4.

Function
REQ-010 pad_sel SHALL pass through a 2-flop synchroniser; edges SHALL be detected on the synchronised value.
REQ-011 A pad_d change SHALL appear exactly 3 clk_sys cycles after a pad_sel transition (2 sync + 1 output register).
REQ-012 Falling-edge counter f SHALL increment on each synchronised falling edge and saturate at 4.
REQ-013 Idle counter SHALL clear on any synchronised edge and increment otherwise, saturating at TIMEOUT_CYC = CLK_HZ/1000000*TIMEOUT_US.
REQ-014 When the idle counter reaches TIMEOUT_CYC, f SHALL clear to 0 on that cycle.
REQ-015 If a sel edge and timeout expiry coincide, the edge SHALL win: idle clears and f increments from its current value.
REQ-016 Sel high and (f!=3 or SIX_BTN=0): pad_d = ~{c,b,right,left,down,up}.
REQ-017 Sel low and (f<=2 or SIX_BTN=0): pad_d = ~{start,a,1,1,down,up}, meaning D2,D3 driven low.
REQ-018 Sel low and f==3 and SIX_BTN=1: pad_d = ~{start,a,1,1,1,1}, meaning D0-D3 all low (6-button ID).
REQ-019 Sel high and f==3 and SIX_BTN=1: pad_d = ~{c,b,mode,x,y,z}.
REQ-020 Sel low and f==4 and SIX_BTN=1: pad_d = ~{start,a,0,0,0,0}, meaning D0-D3 all high.
REQ-021 Sel high and f==4: pad_d SHALL follow REQ-016.
REQ-022 With SIX_BTN=0, f SHALL saturate at 2; phase reports the same value.
REQ-023 btn SHALL be sampled every cycle into the output register; there is no latching across phases.
REQ-024 Output mux SHALL use the synchronised sel and the post-update f, so each response corresponds to the edge just taken.

Reset
REQ-025 During reset: pad_d=6'h3F, f=0, idle counter=0, and synchroniser flops=1 (sel-high idle).
REQ-026 Reset asserted mid-sequence SHALL abort the phase; first falling edge after release yields f=1.
REQ-027 After reset release with sel held high, pad_d SHALL reflect REQ-016 on the first cycle after release.

Verification
REQ-028 Latency: btn=0, toggle pad_sel high->low at cycle T -> pad_d changes 3F->33 at T+3 exactly; no change at T+2.
REQ-029 3-button read: btn[up]=1,btn[a]=1; sel high -> pad_d=3E; sel low -> pad_d=22; phase=1.
REQ-030 6-button sequence: btn[z]=1,btn[mode]=1; 3 low pulses 10 us apart -> third low pad_d=30; next high pad_d=36; fourth low pad_d=3F with D0-D3 high; phase=4.
REQ-031 Timeout: after 2 pulses, hold sel high for TIMEOUT_CYC+5 cycles -> phase=0; next low reports the standard pattern (REQ-017), not the ID.
REQ-032 Coincidence: force a falling edge on the exact cycle the idle counter hits TIMEOUT_CYC with f=2 -> f=3.
REQ-033 SIX_BTN=0 build: 5 pulses -> phase never exceeds 2; D2,D3 low on every low phase; high phase always standard.
